// File: rtl/sisc_pkg.sv
// Shared SISC fetch-stage types and constants.
package sisc_pkg;
  localparam int          DEFAULT_AW       = 16;
  localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } fetch_state_e;
endpackage

// File: rtl/br_calc.sv
// Combinational next-PC selection: sequential, PC-relative or absolute target.
module br_calc
  import sisc_pkg::*;
#(
  parameter int AW = DEFAULT_AW
) (
  input  logic [AW-1:0] pc,
  input  logic [15:0]   imm,
  input  logic          pc_sel,
  input  logic          br_sel,
  output logic [AW-1:0] next_pc
);
  logic [AW-1:0] seq_pc;
  logic [AW-1:0] rel_pc;
  logic [AW-1:0] abs_pc;

  // All sums wrap modulo 2^AW; the relative offset is taken from PC+1.
  assign seq_pc = pc + AW'(1);
  assign rel_pc = seq_pc + AW'($signed(imm));
  assign abs_pc = AW'(imm);

  always_comb begin
    next_pc = seq_pc;
    if (pc_sel) begin
      next_pc = br_sel ? abs_pc : rel_pc;
    end
  end
endmodule

// File: rtl/ifetch_unit.sv
// SISC instruction fetch: PC, branch target, one-outstanding memory request, IR.
// IFETCH_BOUNDS_EN adds a sticky fault for fetch addresses >= IM_DEPTH.
module ifetch_unit
  import sisc_pkg::*;
#(
  parameter int            AW       = DEFAULT_AW,
  parameter logic [AW-1:0] RESET_PC = AW'(DEFAULT_RESET_PC),
  parameter int            IM_DEPTH = 65536
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          ir_load,
  input  logic          pc_write,
  input  logic          pc_sel,
  input  logic          br_sel,
  input  logic [15:0]   imm,
  output logic          im_req,
  output logic [AW-1:0] im_addr,
  input  logic [31:0]   im_rdata,
  input  logic          im_ack,
  output logic [31:0]   ir,
  output logic          ir_valid,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          fault
);
  fetch_state_e  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] im_addr_q, im_addr_d;
  logic [31:0]   ir_q, ir_d;
  logic          ir_valid_q, ir_valid_d;
  logic          im_req_q, im_req_d;
  logic [AW-1:0] next_pc;
  logic [AW-1:0] fetch_addr;
  logic          start_fetch;

  br_calc #(.AW(AW)) u_br_calc (
    .pc      (pc_q),
    .imm     (imm),
    .pc_sel  (pc_sel),
    .br_sel  (br_sel),
    .next_pc (next_pc)
  );

  // A PC update in the same cycle as the fetch request redirects the fetch.
  assign fetch_addr = pc_write ? next_pc : pc_q;

`ifdef IFETCH_BOUNDS_EN
  logic fault_q, fault_d;
  logic out_of_bounds;
  assign out_of_bounds = 32'(fetch_addr) >= 32'(IM_DEPTH);
  assign start_fetch   = ir_load && !out_of_bounds;
  assign fault         = fault_q;
`else
  logic [31:0] unused_im_depth;
  assign unused_im_depth = 32'(IM_DEPTH);
  assign start_fetch     = ir_load;
  assign fault           = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    im_addr_d  = im_addr_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    im_req_d   = im_req_q;
`ifdef IFETCH_BOUNDS_EN
    fault_d    = fault_q;
`endif
    if (pc_write) begin
      pc_d = next_pc;
    end
    case (state_q)
      ST_IDLE: begin
        if (start_fetch) begin
          state_d    = ST_REQ;
          im_req_d   = 1'b1;
          im_addr_d  = fetch_addr;
          ir_valid_d = 1'b0;
        end
`ifdef IFETCH_BOUNDS_EN
        else if (ir_load) begin
          ir_d       = NOP_INSTR;
          ir_valid_d = 1'b1;
          fault_d    = 1'b1;
        end
`endif
      end
      ST_REQ: begin
        if (im_ack) begin
          state_d    = ST_IDLE;
          im_req_d   = 1'b0;
          ir_d       = im_rdata;
          ir_valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      im_addr_q  <= '0;
      ir_q       <= NOP_INSTR;
      ir_valid_q <= 1'b0;
      im_req_q   <= 1'b0;
`ifdef IFETCH_BOUNDS_EN
      fault_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      im_addr_q  <= im_addr_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      im_req_q   <= im_req_d;
`ifdef IFETCH_BOUNDS_EN
      fault_q    <= fault_d;
`endif
    end
  end

  assign pc       = pc_q;
  assign im_req   = im_req_q;
  assign im_addr  = im_addr_q;
  assign ir       = ir_q;
  assign ir_valid = ir_valid_q;
  assign busy     = (state_q == ST_REQ);
endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_ifetch_unit;
  localparam int TB_DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_f;
  logic        ir_load, pc_write, pc_sel, br_sel, im_ack;
  logic [15:0] imm;
  logic [31:0] im_rdata;
  logic        im_req, ir_valid, busy, fault;
  logic [15:0] im_addr, pc;
  logic [31:0] ir;

  int vectors = 0;
  int miscompares = 0;

  ifetch_unit #(.AW(16), .RESET_PC(16'h0000), .IM_DEPTH(TB_DEPTH)) dut (
    .clk(clk), .rst_f(rst_f), .ir_load(ir_load), .pc_write(pc_write),
    .pc_sel(pc_sel), .br_sel(br_sel), .imm(imm), .im_req(im_req),
    .im_addr(im_addr), .im_rdata(im_rdata), .im_ack(im_ack), .ir(ir),
    .ir_valid(ir_valid), .pc(pc), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ir_load = 0; pc_write = 0; pc_sel = 0; br_sel = 0; imm = 16'h0;
    im_ack = 0; im_rdata = 32'h0;
  endtask

  task automatic set_pc(input logic [15:0] v);
    pc_write = 1; pc_sel = 1; br_sel = 1; imm = v;
    step();
    pc_write = 0; pc_sel = 0; br_sel = 0; imm = 16'h0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_f = 0;
    step(); step();
    vectors++; if (pc !== 16'h0) begin miscompares++; $display("FAIL reset_pc got=%h exp=%h", pc, 16'h0); end
    vectors++; if (ir !== 32'h0) begin miscompares++; $display("FAIL reset_ir got=%h exp=%h", ir, 32'h0); end
    vectors++; if (ir_valid !== 1'b0) begin miscompares++; $display("FAIL reset_ir_valid got=%b exp=0", ir_valid); end
    vectors++; if (im_req !== 1'b0) begin miscompares++; $display("FAIL reset_im_req got=%b exp=0", im_req); end
    vectors++; if (im_addr !== 16'h0) begin miscompares++; $display("FAIL reset_im_addr got=%h exp=0", im_addr); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
    vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL reset_fault got=%b exp=0", fault); end
    rst_f = 1;
    step();
  endtask

  task automatic test_basic_fetch();
    ir_load = 1;
    step();
    ir_load = 0;
    vectors++; if (im_req !== 1'b1) begin miscompares++; $display("FAIL fetch_req got=%b exp=1", im_req); end
    vectors++; if (im_addr !== 16'h0) begin miscompares++; $display("FAIL fetch_addr got=%h exp=0", im_addr); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL fetch_busy got=%b exp=1", busy); end
    vectors++; if (ir_valid !== 1'b0) begin miscompares++; $display("FAIL fetch_early_valid got=%b exp=0", ir_valid); end
    im_ack = 1; im_rdata = 32'h11230005;
    step();
    im_ack = 0;
    vectors++; if (ir !== 32'h11230005) begin miscompares++; $display("FAIL fetch_ir got=%h exp=%h", ir, 32'h11230005); end
    vectors++; if (ir_valid !== 1'b1) begin miscompares++; $display("FAIL fetch_valid got=%b exp=1", ir_valid); end
    vectors++; if (im_req !== 1'b0) begin miscompares++; $display("FAIL fetch_req_drop got=%b exp=0", im_req); end
    vectors++; if (pc !== 16'h0) begin miscompares++; $display("FAIL fetch_pc got=%h exp=0", pc); end
  endtask

  task automatic test_pc_arith();
    set_pc(16'hFFFF);
    vectors++; if (pc !== 16'hFFFF) begin miscompares++; $display("FAIL abs_ffff got=%h exp=ffff", pc); end
    pc_write = 1; pc_sel = 0;
    step();
    pc_write = 0;
    vectors++; if (pc !== 16'h0000) begin miscompares++; $display("FAIL seq_wrap got=%h exp=0000", pc); end
    set_pc(16'h0010);
    pc_write = 1; pc_sel = 1; br_sel = 0; imm = 16'hFFFE;
    step();
    vectors++; if (pc !== 16'h000F) begin miscompares++; $display("FAIL rel_neg got=%h exp=000f", pc); end
    br_sel = 1; imm = 16'h0040;
    step();
    vectors++; if (pc !== 16'h0040) begin miscompares++; $display("FAIL abs_40 got=%h exp=0040", pc); end
    br_sel = 0; imm = 16'h0005;
    step();
    pc_write = 0; pc_sel = 0; imm = 0;
    vectors++; if (pc !== 16'h0046) begin miscompares++; $display("FAIL rel_pos got=%h exp=0046", pc); end
  endtask

  task automatic test_load_with_write();
    set_pc(16'h0005);
    ir_load = 1; pc_write = 1; pc_sel = 0;
    step();
    ir_load = 0; pc_write = 0;
    vectors++; if (im_addr !== 16'h0006) begin miscompares++; $display("FAIL lw_addr got=%h exp=0006", im_addr); end
    vectors++; if (pc !== 16'h0006) begin miscompares++; $display("FAIL lw_pc got=%h exp=0006", pc); end
    im_ack = 1; im_rdata = 32'hA5A50001;
    step();
    im_ack = 0;
    vectors++; if (ir !== 32'hA5A50001) begin miscompares++; $display("FAIL lw_ir got=%h exp=a5a50001", ir); end
  endtask

  task automatic test_stall();
    ir_load = 1;
    step();
    ir_load = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin ir_load = 1; pc_write = 1; pc_sel = 0; end
      step();
      ir_load = 0; pc_write = 0;
      vectors++; if (im_req !== 1'b1) begin miscompares++; $display("FAIL stall_req[%0d] got=%b exp=1", i, im_req); end
      vectors++; if (im_addr !== 16'h0006) begin miscompares++; $display("FAIL stall_addr[%0d] got=%h exp=0006", i, im_addr); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL stall_busy[%0d] got=%b exp=1", i, busy); end
      vectors++; if (ir_valid !== 1'b0) begin miscompares++; $display("FAIL stall_valid[%0d] got=%b exp=0", i, ir_valid); end
    end
    vectors++; if (pc !== 16'h0007) begin miscompares++; $display("FAIL stall_pc got=%h exp=0007", pc); end
    im_ack = 1; im_rdata = 32'hDEADBEEF;
    step();
    vectors++; if (ir !== 32'hDEADBEEF) begin miscompares++; $display("FAIL stall_ir got=%h exp=deadbeef", ir); end
    vectors++; if (ir_valid !== 1'b1) begin miscompares++; $display("FAIL stall_ir_valid got=%b exp=1", ir_valid); end
    im_rdata = 32'h12345678;
    step();
    im_ack = 0;
    vectors++; if (ir !== 32'hDEADBEEF) begin miscompares++; $display("FAIL idle_ack_ir got=%h exp=deadbeef", ir); end
    vectors++; if (im_req !== 1'b0) begin miscompares++; $display("FAIL no_queued_load got=%b exp=0", im_req); end
  endtask

  task automatic test_reset_mid_fetch();
    ir_load = 1;
    step();
    ir_load = 0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rst_mid_busy_pre got=%b exp=1", busy); end
    #2 rst_f = 0;
    #1;
    vectors++; if (im_req !== 1'b0) begin miscompares++; $display("FAIL rst_mid_req got=%b exp=0", im_req); end
    vectors++; if (pc !== 16'h0) begin miscompares++; $display("FAIL rst_mid_pc got=%h exp=0", pc); end
    vectors++; if (ir !== 32'h0) begin miscompares++; $display("FAIL rst_mid_ir got=%h exp=0", ir); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    @(negedge clk);
    rst_f = 1;
    im_ack = 1; im_rdata = 32'hF00DF00D;
    step();
    im_ack = 0;
    vectors++; if (ir !== 32'h0) begin miscompares++; $display("FAIL rst_ack_ir got=%h exp=0", ir); end
    vectors++; if (ir_valid !== 1'b0) begin miscompares++; $display("FAIL rst_ack_valid got=%b exp=0", ir_valid); end
  endtask

  task automatic test_random();
    logic [15:0] m_pc, m_addr, nxt, fa;
    logic [31:0] m_ir;
    logic        m_irv, m_busy, m_fault;
    rst_f = 0; clear_inputs();
    #2 rst_f = 1;
    m_pc = 16'h0; m_addr = 16'h0; m_ir = 32'h0; m_irv = 0; m_busy = 0; m_fault = 0;
    for (int n = 0; n < 300; n++) begin
      ir_load  = ($urandom_range(0, 2) == 0);
      pc_write = ($urandom_range(0, 2) == 0);
      pc_sel   = 1'($urandom);
      br_sel   = ($urandom_range(0, 3) == 0);
      imm      = (br_sel) ? 16'($urandom_range(0, 40)) : 16'($urandom);
      im_ack   = ($urandom_range(0, 4) < 2);
      im_rdata = $urandom;
      if (!pc_sel) nxt = m_pc + 16'd1;
      else if (!br_sel) nxt = 16'(int'(m_pc) + 1 + int'($signed(imm)));
      else nxt = imm;
      fa = pc_write ? nxt : m_pc;
      if (m_busy) begin
        if (im_ack) begin m_ir = im_rdata; m_irv = 1; m_busy = 0; end
      end else if (ir_load) begin
`ifdef IFETCH_BOUNDS_EN
        if (int'(fa) >= TB_DEPTH) begin m_ir = 32'h0; m_irv = 1; m_fault = 1; end
        else begin m_busy = 1; m_addr = fa; m_irv = 0; end
`else
        m_busy = 1; m_addr = fa; m_irv = 0;
`endif
      end
      if (pc_write) m_pc = nxt;
      step();
      vectors++; if (pc !== m_pc) begin miscompares++; $display("FAIL rnd_pc[%0d] got=%h exp=%h", n, pc, m_pc); end
      vectors++; if (ir !== m_ir) begin miscompares++; $display("FAIL rnd_ir[%0d] got=%h exp=%h", n, ir, m_ir); end
      vectors++; if (ir_valid !== m_irv) begin miscompares++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", n, ir_valid, m_irv); end
      vectors++; if (im_req !== m_busy) begin miscompares++; $display("FAIL rnd_req[%0d] got=%b exp=%b", n, im_req, m_busy); end
      vectors++; if (busy !== m_busy) begin miscompares++; $display("FAIL rnd_busy[%0d] got=%b exp=%b", n, busy, m_busy); end
      vectors++; if (fault !== m_fault) begin miscompares++; $display("FAIL rnd_fault[%0d] got=%b exp=%b", n, fault, m_fault); end
      if (m_busy) begin
        vectors++; if (im_addr !== m_addr) begin miscompares++; $display("FAIL rnd_addr[%0d] got=%h exp=%h", n, im_addr, m_addr); end
      end
    end
    clear_inputs();
  endtask

  task automatic test_bounds();
    rst_f = 0; clear_inputs();
    #2 rst_f = 1;
    step();
    set_pc(16'd15);
    ir_load = 1;
    step();
    ir_load = 0;
    vectors++; if (im_req !== 1'b1) begin miscompares++; $display("FAIL bnd_15_req got=%b exp=1", im_req); end
    im_ack = 1; im_rdata = 32'h0BADCAFE;
    step();
    im_ack = 0;
    set_pc(16'd16);
    ir_load = 1;
    step();
    ir_load = 0;
`ifdef IFETCH_BOUNDS_EN
    vectors++; if (im_req !== 1'b0) begin miscompares++; $display("FAIL bnd_16_req got=%b exp=0", im_req); end
    vectors++; if (ir !== 32'h0) begin miscompares++; $display("FAIL bnd_16_ir got=%h exp=0", ir); end
    vectors++; if (ir_valid !== 1'b1) begin miscompares++; $display("FAIL bnd_16_valid got=%b exp=1", ir_valid); end
    vectors++; if (fault !== 1'b1) begin miscompares++; $display("FAIL bnd_16_fault got=%b exp=1", fault); end
    step(); step();
    vectors++; if (fault !== 1'b1) begin miscompares++; $display("FAIL bnd_sticky got=%b exp=1", fault); end
`else
    vectors++; if (im_req !== 1'b1) begin miscompares++; $display("FAIL nobnd_16_req got=%b exp=1", im_req); end
    vectors++; if (im_addr !== 16'd16) begin miscompares++; $display("FAIL nobnd_16_addr got=%h exp=0010", im_addr); end
    vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL nobnd_fault got=%b exp=0", fault); end
    im_ack = 1; im_rdata = 32'h00C0FFEE;
    step();
    im_ack = 0;
    vectors++; if (ir !== 32'h00C0FFEE) begin miscompares++; $display("FAIL nobnd_ir got=%h exp=00c0ffee", ir); end
`endif
  endtask

  initial begin
    rst_f = 0;
    clear_inputs();
    test_reset();
    test_basic_fetch();
    test_pc_arith();
    test_load_with_write();
    test_stall();
    test_reset_mid_fetch();
    test_random();
    test_bounds();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
